traffic_lamp_monitor: RTL
=========================

Name: traffic_lamp_monitor

Overview:
Safety monitor on the six lamp lines driven by the intersection controller: RA, OA, GA for road A and RB, OB, GB for road B.
- Decodes the lamp pattern back into a phase code.
- Checks pattern legality, phase order and minimum dwell per phase.
- Latches the first violation with a fault code.
- Sits beside the controller as the lamp interface's receiving end; feeds the supervisor/fault-display logic.

Parameters:
GREEN_A_MIN, 60, minimum cycles phase 0 (GA+RB) must persist
AMBER_A_MIN, 10, minimum cycles phase 1 (OA+RB)
GREEN_B_MIN, 30, minimum cycles phase 2 (GB+RA)
AMBER_B_MIN, 10, minimum cycles phase 3 (OB+RA)
CNT_W, 8, dwell counter width
MAX_DWELL, 200, watchdog limit (only with optional feature)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
RA, OA, GA  in  1 each  road A red/amber/green lamp
RB, OB, GB  in  1 each  road B red/amber/green lamp
clear_fault  in  1  synchronous request to leave FAULT
phase  out  2  decoded current phase, 0..3
phase_valid  out  1  phase is being tracked (state TRACK)
phase_change  out  1  one-cycle pulse on an accepted phase transition
dwell  out  CNT_W  cycles current phase has been held, saturating
fault  out  1  latched violation flag
fault_code  out  3  0 none, 1 illegal pattern, 2 sequence skip, 3 short dwell, 4 watchdog

Behaviour:
- Interface: one clock clk; reset is asynchronous and active-high. On reset:
  - lamp_q=0, state INIT, phase=0.
  - phase_valid=0, phase_change=0, dwell=0.
  - fault=0, fault_code=0.
- Input stage: the six lamps are registered into lamp_q at every edge. All decoding uses lamp_q only.
- Latency: a lamp change sampled at edge k shows on phase/fault/dwell after edge k+1, i.e. 2 cycles from the input change.
- Decode of lamp_q; exactly these patterns are legal, anything else (all-off, two lamps on one road, both green, etc.) is illegal:
  - P0 = GA,RB only
  - P1 = OA,RB only
  - P2 = GB,RA only
  - P3 = OB,RA only
- State INIT:
  - Illegal patterns are ignored.
  - First legal pattern Pn -> TRACK, phase=n, dwell=1, phase_valid=1.
  - No dwell check applies to this first phase.
- State TRACK, evaluated in priority order:
  - Illegal pattern -> FAULT, code 1.
  - Legal Pm with m != phase and m != (phase+1) mod 4 -> FAULT, code 2.
  - m == (phase+1) mod 4 with dwell < MIN(phase) -> FAULT, code 3.
  - Otherwise accept the transition: phase=m, dwell=1, phase_change=1 for one cycle.
  - Same pattern -> dwell+1, saturating at 2^CNT_W-1. Saturation is not a fault without the option.
- State FAULT:
  - fault=1; fault_code holds the first violation; phase_valid=0.
  - phase and dwell freeze; further violations do not overwrite the code.
  - clear_fault=1 -> INIT next edge; fault, fault_code and dwell clear to 0.
- clear_fault outside FAULT is ignored. In FAULT, clear_fault beats any new violation in the same cycle.
- Reset asserted mid-operation returns everything to reset values immediately, independent of clk.
- Phase 3 -> 0 wrap is a legal successor.

Optional Feature:
LAMP_MON_WATCHDOG_EN
- Defined: in TRACK, dwell reaching MAX_DWELL -> FAULT, code 4. Priority is below codes 1-3. Phase 0 is also subject to it (a stuck green is a fault).
- Undefined: no watchdog logic; code 4 is never produced; dwell simply saturates.

Test Plan:
- Reset, drive P0 60, P1 10, P2 30, P3 10 cycles, repeat twice -> phase 0,1,2,3,0; phase_change pulses 2 cycles after each lamp edge; fault=0.
- Track P0 for 70 cycles, then drive GA=1, GB=1 -> fault=1, code=1 two cycles after; clear_fault -> INIT, fault=0.
- P0 for 60 cycles, then jump to P2 -> code 2; phase stays 0.
- Full P0, then P1 for only 5 cycles, then P2 -> code 3; dwell frozen at 5.
- Assert reset asynchronously mid-P2 -> all outputs 0 without a clock edge; after release, all-off lamps stay in INIT with phase_valid=0.
- With LAMP_MON_WATCHDOG_EN and MAX_DWELL=200, hold P0 -> code 4 when dwell reaches 200; without the macro, dwell saturates at 255 and no fault.

Source files
------------

// File: rtl/traffic_lamp_monitor_if.sv
// Lamp-monitor interface: the six lamp lines and fault clear from the controller side,
// decoded phase / dwell / fault status back from the monitor.
interface traffic_lamp_monitor_if #(
    parameter int unsigned CNT_W = 8
);
    // Lamp lines: road A red/amber/green, road B red/amber/green
    logic             ra;
    logic             oa;
    logic             ga;
    logic             rb;
    logic             ob;
    logic             gb;
    logic             clear_fault;
    // Monitor status
    logic [1:0]       phase;
    logic             phase_valid;
    logic             phase_change;
    logic [CNT_W-1:0] dwell;
    logic             fault;
    logic [2:0]       fault_code;

    // Controller / supervisor side
    modport master (
        output ra, oa, ga, rb, ob, gb, clear_fault,
        input  phase, phase_valid, phase_change, dwell, fault, fault_code
    );

    // Monitor side
    modport slave (
        input  ra, oa, ga, rb, ob, gb, clear_fault,
        output phase, phase_valid, phase_change, dwell, fault, fault_code
    );
endinterface

// File: rtl/traffic_lamp_monitor.sv
// Safety monitor for the intersection lamp lines. Registers the lamps, decodes them to a
// phase, checks legality, phase order and minimum dwell, and latches the first violation.
// Optional watchdog on excessive dwell: define LAMP_MON_WATCHDOG_EN (adds MAX_DWELL).
module traffic_lamp_monitor #(
    parameter int unsigned GREEN_A_MIN = 60,
    parameter int unsigned AMBER_A_MIN = 10,
    parameter int unsigned GREEN_B_MIN = 30,
    parameter int unsigned AMBER_B_MIN = 10,
    parameter int unsigned CNT_W       = 8
`ifdef LAMP_MON_WATCHDOG_EN
    ,
    parameter int unsigned MAX_DWELL   = 200
`endif
) (
    input logic                   clk,
    input logic                   reset,
    traffic_lamp_monitor_if.slave bus
);
    typedef enum logic [1:0] {StInit, StTrack, StFault} state_e;

    localparam logic [CNT_W-1:0] DwellSat = '1;
    localparam logic [CNT_W-1:0] DwellOne = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [2:0] CodeNone    = 3'd0;
    localparam logic [2:0] CodeIllegal = 3'd1;
    localparam logic [2:0] CodeSkip    = 3'd2;
    localparam logic [2:0] CodeShort   = 3'd3;
`ifdef LAMP_MON_WATCHDOG_EN
    localparam logic [2:0] CodeWdog    = 3'd4;
    localparam logic [CNT_W-1:0] WdLimit = CNT_W'(MAX_DWELL);
`endif

    // Lamp bits ordered {ra, oa, ga, rb, ob, gb}
    logic [5:0]       r_lamp;
    state_e           r_state, w_state_next;
    logic [1:0]       r_phase, w_phase_next;
    logic [CNT_W-1:0] r_dwell, w_dwell_next;
    logic             r_change, w_change_next;
    logic [2:0]       r_code, w_code_next;
    logic             w_legal;
    logic [1:0]       w_pat;
    logic [1:0]       w_succ;
    logic [CNT_W-1:0] w_min;
    logic             w_phase_valid;
    logic             w_fault;

    // Input stage: all checking works from the registered lamps only
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lamp <= 6'b0;
        end else begin
            r_lamp <= {bus.ra, bus.oa, bus.ga, bus.rb, bus.ob, bus.gb};
        end
    end

    // Decode registered lamps into a phase number and legality flag
    always_comb begin
        w_legal = 1'b1;
        w_pat   = 2'd0;
        case (r_lamp)
            6'b001_100: w_pat = 2'd0;
            6'b010_100: w_pat = 2'd1;
            6'b100_001: w_pat = 2'd2;
            6'b100_010: w_pat = 2'd3;
            default:    w_legal = 1'b0;
        endcase
    end

    // Successor phase (3 wraps to 0) and minimum dwell of the current phase
    always_comb begin
        w_succ = r_phase + 2'd1;
        case (r_phase)
            2'd0:    w_min = CNT_W'(GREEN_A_MIN);
            2'd1:    w_min = CNT_W'(AMBER_A_MIN);
            2'd2:    w_min = CNT_W'(GREEN_B_MIN);
            default: w_min = CNT_W'(AMBER_B_MIN);
        endcase
    end

    // State and tracking registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= StInit;
            r_phase  <= 2'd0;
            r_dwell  <= '0;
            r_change <= 1'b0;
            r_code   <= CodeNone;
        end else begin
            r_state  <= w_state_next;
            r_phase  <= w_phase_next;
            r_dwell  <= w_dwell_next;
            r_change <= w_change_next;
            r_code   <= w_code_next;
        end
    end

    // Next-state: checks in TRACK are ordered by fault-code priority
    always_comb begin
        w_state_next  = r_state;
        w_phase_next  = r_phase;
        w_dwell_next  = r_dwell;
        w_code_next   = r_code;
        w_change_next = 1'b0;
        case (r_state)
            StInit: begin
                if (w_legal) begin
                    w_state_next = StTrack;
                    w_phase_next = w_pat;
                    w_dwell_next = DwellOne;
                end
            end
            StTrack: begin
                if (!w_legal) begin
                    w_state_next = StFault;
                    w_code_next  = CodeIllegal;
                end else if (w_pat == r_phase) begin
`ifdef LAMP_MON_WATCHDOG_EN
                    if (r_dwell >= WdLimit) begin
                        w_state_next = StFault;
                        w_code_next  = CodeWdog;
                    end else if (r_dwell != DwellSat) begin
`else
                    if (r_dwell != DwellSat) begin
`endif
                        w_dwell_next = r_dwell + 1'b1;
                    end
                end else if (w_pat != w_succ) begin
                    w_state_next = StFault;
                    w_code_next  = CodeSkip;
                end else if (r_dwell < w_min) begin
                    w_state_next = StFault;
                    w_code_next  = CodeShort;
                end else begin
                    w_phase_next  = w_pat;
                    w_dwell_next  = DwellOne;
                    w_change_next = 1'b1;
                end
            end
            StFault: begin
                // Phase and dwell hold; only a clear leaves this state
                if (bus.clear_fault) begin
                    w_state_next = StInit;
                    w_dwell_next = '0;
                    w_code_next  = CodeNone;
                end
            end
            default: w_state_next = StInit;
        endcase
    end

    // Outputs decoded from the state register
    always_comb begin
        w_phase_valid = (r_state == StTrack);
        w_fault       = (r_state == StFault);
    end

    assign bus.phase        = r_phase;
    assign bus.phase_valid  = w_phase_valid;
    assign bus.phase_change = r_change;
    assign bus.dwell        = r_dwell;
    assign bus.fault        = w_fault;
    assign bus.fault_code   = r_code;
endmodule
